// File: rtl/data_mem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU path, debug/loader)
// and the single-ported data memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter (CPU path, debug/loader) for the single-ported data memory.
// Define DATA_MEM_ARB_CPU_PRIORITY_EN for fixed CPU priority on ties; default is round-robin.
module data_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    data_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              take;
    logic              pick_dbg;
    logic              own_dbg;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              cpu_rvalid_q;
    logic              dbg_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;

`ifdef DATA_MEM_ARB_CPU_PRIORITY_EN
    assign pick_dbg = bus.dbg_req & ~bus.cpu_req;
`else
    // last_dbg starts at 1 so the CPU wins the first tie after reset
    logic last_dbg;

    assign pick_dbg = bus.dbg_req & (~bus.cpu_req | ~last_dbg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dbg <= 1'b1;
        end else if (take) begin
            last_dbg <= pick_dbg;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req | bus.dbg_req) begin
                    state_nxt = ACCESS;
                    take      = 1'b1;
                end
            end
            ACCESS:  state_nxt = cap_we ? IDLE : RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture stage: the winner's fields feed the memory strobes directly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own_dbg   <= 1'b0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
        end else if (take) begin
            own_dbg   <= pick_dbg;
            cap_we    <= pick_dbg ? bus.dbg_we    : bus.cpu_we;
            cap_addr  <= pick_dbg ? bus.dbg_addr  : bus.cpu_addr;
            cap_wdata <= pick_dbg ? bus.dbg_wdata : bus.cpu_wdata;
        end
    end

    // Read return stage: only the owner's data register is updated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            cpu_rvalid_q <= (state == RD_WAIT) && !own_dbg;
            dbg_rvalid_q <= (state == RD_WAIT) && own_dbg;
            if (state == RD_WAIT) begin
                if (own_dbg) begin
                    dbg_rdata_q <= bus.mem_rdata;
                end else begin
                    cpu_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.cpu_gnt    = (state == ACCESS) && !own_dbg;
    assign bus.dbg_gnt    = (state == ACCESS) && own_dbg;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dbg_rvalid = dbg_rvalid_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.dbg_rdata  = dbg_rdata_q;
    assign bus.mem_en     = (state == ACCESS);
    assign bus.mem_we     = (state == ACCESS) && cap_we;
    assign bus.mem_addr   = cap_addr;
    assign bus.mem_wdata  = cap_wdata;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a reference model predicts every grant, memory
// access and read return; a negedge monitor pops and compares as the DUT presents them.
module tb_data_mem_arbiter;
    localparam int AW = 11;
    localparam int DW = 8;

    typedef struct packed {
        logic          dbg;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a[7:0] ^ {5'b0, a[10:8]} ^ 8'hC3;
    endfunction

    // Behavioural single-port memory: read data appears one cycle after the strobe
    logic [DW-1:0] mem [2048];
    bit            written [2048];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem[bus.mem_addr]     <= bus.mem_wdata;
                written[bus.mem_addr] <= 1'b1;
            end else begin
                bus.mem_rdata <= written[bus.mem_addr] ? mem[bus.mem_addr] : init_val(bus.mem_addr);
            end
        end
    end

    // Reference model state
    logic [DW-1:0] ref_mem [2048];
    bit            ref_wr [2048];
    bit            last_dbg = 1'b1;
    acc_t          exp_acc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic void model_push(input bit dbg, input bit we, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d);
        acc_t e;
        e.dbg   = dbg;
        e.we    = we;
        e.addr  = a;
        e.wdata = d;
        e.rdata = '0;
        if (we) begin
            ref_mem[a] = d;
            ref_wr[a]  = 1'b1;
        end else begin
            e.rdata = ref_wr[a] ? ref_mem[a] : init_val(a);
        end
        exp_acc.push_back(e);
        last_dbg = dbg;
    endfunction

    // Monitor
    bit            rd_pend = 1'b0;
    acc_t          rd_e;
    int            rd_due = 0;
    logic [DW-1:0] sh_cpu = '0;
    logic [DW-1:0] sh_dbg = '0;
    bit            prev_rd = 1'b0;
    bit            gnt_any;
    bit            nxt_prev_rd;
    acc_t          cur;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            rd_pend = 1'b0;
            prev_rd = 1'b0;
            sh_cpu  = '0;
            sh_dbg  = '0;
        end else begin
            gnt_any     = bus.cpu_gnt | bus.dbg_gnt;
            nxt_prev_rd = 1'b0;
            chk("gnt_exclusive", {31'b0, bus.cpu_gnt & bus.dbg_gnt}, 0);
            chk("busy", {31'b0, bus.busy}, {31'b0, gnt_any | prev_rd});
            chk("mem_en", {31'b0, bus.mem_en}, {31'b0, gnt_any});
            if (!bus.mem_en) chk("mem_we_without_en", {31'b0, bus.mem_we}, 0);
            if (bus.cpu_rvalid | bus.dbg_rvalid) begin
                if (!rd_pend) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rvalid: got cpu=%0b dbg=%0b want none", bus.cpu_rvalid, bus.dbg_rvalid);
                end else begin
                    chk("rvalid_owner", {31'b0, bus.dbg_rvalid}, {31'b0, rd_e.dbg});
                    chk("rvalid_both", {31'b0, bus.cpu_rvalid & bus.dbg_rvalid}, 0);
                    chk("rvalid_latency", cyc, rd_due);
                    chk("rdata", rd_e.dbg ? bus.dbg_rdata : bus.cpu_rdata, rd_e.rdata);
                    if (rd_e.dbg) sh_dbg = rd_e.rdata;
                    else sh_cpu = rd_e.rdata;
                    rd_pend = 1'b0;
                end
            end
            if (rd_pend && cyc >= rd_due) begin
                total++;
                bad++;
                $display("FAIL missing_rvalid: got none want owner_dbg=%0b", rd_e.dbg);
                rd_pend = 1'b0;
            end
            chk("cpu_rdata_hold", bus.cpu_rdata, sh_cpu);
            chk("dbg_rdata_hold", bus.dbg_rdata, sh_dbg);
            if (gnt_any) begin
                if (exp_acc.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_gnt: got cpu=%0b dbg=%0b addr=%0h want none", bus.cpu_gnt, bus.dbg_gnt, bus.mem_addr);
                end else begin
                    cur = exp_acc.pop_front();
                    chk("gnt_owner", {31'b0, bus.dbg_gnt}, {31'b0, cur.dbg});
                    chk("mem_we", {31'b0, bus.mem_we}, {31'b0, cur.we});
                    chk("mem_addr", bus.mem_addr, cur.addr);
                    if (cur.we) begin
                        chk("mem_wdata", bus.mem_wdata, cur.wdata);
                    end else begin
                        rd_pend     = 1'b1;
                        rd_e        = cur;
                        rd_due      = cyc + 2;
                        nxt_prev_rd = 1'b1;
                    end
                end
            end
            prev_rd = nxt_prev_rd;
        end
    end

    task automatic drive(input bit dbg, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int gcyc);
        @(negedge clk);
        if (dbg) begin
            bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
        end
        gcyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((dbg ? bus.dbg_gnt : bus.cpu_gnt) === 1'b1) begin
                gcyc = cyc;
                break;
            end
        end
        if (dbg) bus.dbg_req = 1'b0;
        else bus.cpu_req = 1'b0;
        if (gcyc < 0) begin
            total++;
            bad++;
            $display("FAIL gnt_timeout: got no grant want grant for dbg=%0b addr=%0h", dbg, a);
        end
    endtask

    task automatic round(input bit c_on, input bit c_we, input logic [AW-1:0] c_a, input logic [DW-1:0] c_d,
                         input bit d_on, input bit d_we, input logic [AW-1:0] d_a, input logic [DW-1:0] d_d);
        bit first_dbg;
        int gc, gd;
        if (c_on && d_on) begin
`ifdef DATA_MEM_ARB_CPU_PRIORITY_EN
            first_dbg = 1'b0;
`else
            first_dbg = !last_dbg;
`endif
            if (first_dbg) begin
                model_push(1'b1, d_we, d_a, d_d);
                model_push(1'b0, c_we, c_a, c_d);
            end else begin
                model_push(1'b0, c_we, c_a, c_d);
                model_push(1'b1, d_we, d_a, d_d);
            end
        end else if (c_on) begin
            model_push(1'b0, c_we, c_a, c_d);
        end else if (d_on) begin
            model_push(1'b1, d_we, d_a, d_d);
        end
        fork
            begin if (c_on) drive(1'b0, c_we, c_a, c_d, gc); end
            begin if (d_on) drive(1'b1, d_we, d_a, d_d, gd); end
        join
    endtask

    task automatic wait_rvalid(input bit dbg, output int rc);
        rc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if ((dbg ? bus.dbg_rvalid : bus.cpu_rvalid) === 1'b1) begin
                rc = cyc;
                break;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cpu_gnt"}, {31'b0, bus.cpu_gnt}, 0);
        chk({tag, "_dbg_gnt"}, {31'b0, bus.dbg_gnt}, 0);
        chk({tag, "_cpu_rvalid"}, {31'b0, bus.cpu_rvalid}, 0);
        chk({tag, "_dbg_rvalid"}, {31'b0, bus.dbg_rvalid}, 0);
        chk({tag, "_mem_en"}, {31'b0, bus.mem_en}, 0);
        chk({tag, "_mem_we"}, {31'b0, bus.mem_we}, 0);
        chk({tag, "_busy"}, {31'b0, bus.busy}, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
        chk({tag, "_dbg_rdata"}, bus.dbg_rdata, 0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        case ($urandom_range(0, 4))
            0: return 11'h000;
            1: return 11'h7FF;
            2: return 11'h0FF;
            3: return 11'($urandom_range(0, 7));
            default: return 11'($urandom_range(0, 2047));
        endcase
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: got no end want finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g1, g2, rc, mode;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        repeat (3) @(negedge clk);
        chk_reset("por");
        #2 rst_n = 1'b1;

        // CPU write only
        round(1'b1, 1'b1, 11'h105, 8'hA5, 1'b0, 1'b0, 11'h0, 8'h0);
        repeat (2) @(negedge clk);

        // DBG read of untouched location 0x0FF (holds 0x3C)
        round(1'b0, 1'b0, 11'h0, 8'h0, 1'b1, 1'b0, 11'h0FF, 8'h0);
        wait_rvalid(1'b1, rc);
        chk("dbg_read_0ff", bus.dbg_rdata, 8'h3C);
        @(negedge clk);

        // Held ties: expected CPU, DBG, CPU, DBG in the round-robin build
        for (int k = 0; k < 2; k++) begin
            round(1'b1, k[0], 11'h010 + 11'(k), 8'h20 + 8'(k), 1'b1, 1'b1, 11'h020 + 11'(k), 8'h40 + 8'(k));
        end

        // Write-then-read by the CPU with a one-cycle request gap
        model_push(1'b0, 1'b1, 11'h7FF, 8'h5A);
        drive(1'b0, 1'b1, 11'h7FF, 8'h5A, g1);
        @(negedge clk);
        model_push(1'b0, 1'b0, 11'h7FF, 8'h00);
        drive(1'b0, 1'b0, 11'h7FF, 8'h00, g2);
        wait_rvalid(1'b0, rc);
        chk("wr_rd_latency", rc - g1, 5);
        chk("wr_rd_data", bus.cpu_rdata, 8'h5A);

        // DBG request pulsed only while the CPU access is in ACCESS
        model_push(1'b0, 1'b1, 11'h200, 8'h11);
        fork
            drive(1'b0, 1'b1, 11'h200, 8'h11, g1);
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (bus.cpu_gnt === 1'b1) break;
                end
                bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_addr = 11'h300; bus.dbg_wdata = 8'hEE;
                @(negedge clk);
                bus.dbg_req = 1'b0;
            end
        join
        repeat (4) @(negedge clk);

        // Reset asserted during RD_WAIT of a DBG read
        round(1'b0, 1'b0, 11'h0, 8'h0, 1'b1, 1'b0, 11'h105, 8'h0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_rd");
        exp_acc.delete();
        last_dbg = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rvalid_in_reset", {31'b0, bus.cpu_rvalid | bus.dbg_rvalid}, 0);
        end
        #2 rst_n = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            mode = int'($urandom_range(0, 2));
            round(mode != 1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)),
                  mode != 0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (6) @(negedge clk);
        chk("queue_drained", exp_acc.size(), 0);
        chk("no_read_pending", {31'b0, rd_pend}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
